tap_sync_rx: RTL and testbench

- Clocked receiver directly downstream of the two-phase toggle request generator (req flips once per event, reset value 0).
- Synchronises the toggling request into the clk domain and captures the bundled data word into a small FIFO.
- Returns a two-phase acknowledge toggle, closing the handshake.
- Presents captured words to synchronous logic on a valid/ready interface.

---
 rtl/tap_sync_rx.sv | 199 +++++++++++++++++++
 tb/tb_tap_sync_rx.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tap_sync_rx.sv
// -----------------------------------------------------------------------------
// tap_sync_rx
//   Receiving end of a two-phase (toggle) request/acknowledge handshake. The
//   toggling req_i is brought into the clk domain through a flop chain. Each
//   detected level change is one token, and its bundled data_i word is
//   captured into a small FIFO. Capturing a token toggles ack_o, which closes
//   the handshake. Captured words are offered on a valid/ready interface.
//
// Ports
//   clk        receiver clock
//   rst        asynchronous active-high reset, clears all state
//   req_i      two-phase request, one token per level change
//   data_i     bundled data, stable from the req_i toggle until ack_o matches
//   ack_o      two-phase acknowledge, toggles once per accepted token
//   out_valid  FIFO head valid
//   out_ready  consumer accepts the head this cycle
//   out_data   FIFO head word (registered)
//   fifo_cnt   current occupancy
//   tok_cnt    16-bit wrapping count of accepted tokens
//              (only when TAP_SYNC_RX_CNT_EN is defined)
//
// Optional feature macro: TAP_SYNC_RX_CNT_EN
// -----------------------------------------------------------------------------
module tap_sync_rx #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ack_o,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
`ifdef TAP_SYNC_RX_CNT_EN
  output logic [15:0]                tok_cnt,
`endif
  output logic [$clog2(DEPTH):0]     fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_sync_s;
  logic                   req_seen_r;
  logic                   tok_s;
  logic                   push_s;
  logic                   pop_s;
  state_t                 state_r;
  state_t                 state_nxt_s;

  logic [DATA_W-1:0]      mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [AW-1:0]          rd_ptr_nxt_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;
  logic                   out_valid_r;
  logic [DATA_W-1:0]      out_data_r;
  logic [DATA_W-1:0]      head_nxt_s;

  assign req_sync_s = sync_r[SYNC_STAGES-1];
  assign tok_s      = req_sync_s ^ req_seen_r;
  assign pop_s      = out_valid_r & out_ready;
  // A full FIFO still accepts a token when the head leaves in the same cycle.
  assign push_s     = tok_s & ((cnt_r < DEPTH_C) | pop_s);

  assign ack_o      = req_seen_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign fifo_cnt   = cnt_r;

  // Synchroniser chain sampling the asynchronous request toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], req_i};
    end
  end

  // Handshake state register; req_seen doubles as the acknowledge level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      req_seen_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      if (push_s) begin
        req_seen_r <= req_sync_s;
      end else begin
        req_seen_r <= req_seen_r;
      end
    end
  end

  // Token tracking: a token is pushed in the cycle it becomes visible if space allows.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (tok_s && !push_s) begin
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PEND: begin
        if (push_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PEND;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Next occupancy, read pointer and registered head word.
  always_comb begin
    cnt_nxt_s    = cnt_r;
    rd_ptr_nxt_s = rd_ptr_r;
    head_nxt_s   = out_data_r;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + CW'(1'b1);
      2'b01:   cnt_nxt_s = cnt_r - CW'(1'b1);
      default: cnt_nxt_s = cnt_r;
    endcase
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // The new head is the word being written whenever the FIFO would
    // otherwise be empty after this cycle's pop.
    if (push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
      head_nxt_s = data_i;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO pointers, occupancy and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= (cnt_nxt_s != {CW{1'b0}});
      out_data_r  <= head_nxt_s;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

`ifdef TAP_SYNC_RX_CNT_EN
  logic [15:0] tok_cnt_r;

  assign tok_cnt = tok_cnt_r;

  // Accepted-token counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tok_cnt_r <= 16'h0000;
    end else if (push_s) begin
      tok_cnt_r <= tok_cnt_r + 16'h0001;
    end else begin
      tok_cnt_r <= tok_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_tap_sync_rx.sv
module tb_tap_sync_rx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;

  logic              clk;
  logic              rst;
  logic              req_i;
  logic [DATA_W-1:0] data_i;
  logic              ack_o;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        fifo_cnt;
`ifdef TAP_SYNC_RX_CNT_EN
  logic [15:0]       tok_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  tap_sync_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef TAP_SYNC_RX_CNT_EN
    .tok_cnt(tok_cnt),
`endif
    .fifo_cnt(fifo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sender side: toggle request, record expected word, wait for ack (bounded).
  task automatic send_token(input logic [DATA_W-1:0] d, input bit wait_ack);
    @(negedge clk);
    data_i = d;
    req_i  = ~req_i;
    exp_q.push_back(d);
    if (wait_ack) begin
      int n = 0;
      while (ack_o !== req_i && n < 12) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (ack_o !== req_i) begin
        errors++;
        $display("FAIL ack_wait: ack_o=%b required %b", ack_o, req_i);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; req_i = 1'b0; data_i = '0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ack_o !== 1'b0 || out_valid !== 1'b0 || fifo_cnt !== 3'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_async: ack=%b valid=%b cnt=%0d data=%h required 0 0 0 0",
               ack_o, out_valid, fifo_cnt, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ack_o !== 1'b0 || out_valid !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_release: ack=%b valid=%b cnt=%0d required 0 0 0",
               ack_o, out_valid, fifo_cnt);
    end
  endtask

  task automatic test_single();
    logic [DATA_W-1:0] e;
    out_ready = 1'b1;
    send_token(32'hA5A5_0001, 1'b0);
    // Edges E0 and E0+1: nothing visible yet.
    for (int k = 1; k <= SYNC; k++) begin
      @(negedge clk);
      if (k < SYNC) begin
        checks++;
        if (ack_o !== 1'b0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL single_early_%0d: ack=%b valid=%b required 0 0", k, ack_o, out_valid);
        end
      end
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (ack_o !== 1'b1 || out_valid !== 1'b1 || out_data !== e) begin
      errors++;
      $display("FAIL single_latency: ack=%b valid=%b data=%h required 1 1 %h",
               ack_o, out_valid, out_data, e);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL single_drop: valid=%b cnt=%0d required 0 0", out_valid, fifo_cnt);
    end
  endtask

  task automatic test_fill_backpressure();
    logic ack_hold;
    logic [DATA_W-1:0] e;
    int bad;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_token(DATA_W'(i), 1'b1);
    @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd4) begin
      errors++;
      $display("FAIL fill_cnt: cnt=%0d required 4", fifo_cnt);
    end
    ack_hold = ack_o;
    send_token(32'd5, 1'b0);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack_o !== ack_hold || fifo_cnt !== 3'd4) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_hold: %0d bad cycles, ack=%b cnt=%0d required ack %b cnt 4",
               bad, ack_o, fifo_cnt, ack_hold);
    end
    out_ready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e) begin
      errors++;
      $display("FAIL full_pop_head: valid=%b data=%h required 1 %h", out_valid, out_data, e);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (ack_o !== ~ack_hold || fifo_cnt !== 3'd4) begin
      errors++;
      $display("FAIL full_pop_push: ack=%b cnt=%0d required %b 4", ack_o, fifo_cnt, ~ack_hold);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, e);
      end
      @(negedge clk);
    end
    checks++;
    if (out_valid !== 1'b0 || fifo_cnt !== 3'd0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b cnt=%0d required 0 0", out_valid, fifo_cnt);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] e;
    out_ready = 1'b0;
    send_token(32'h10, 1'b1);
    send_token(32'h11, 1'b1);
    @(negedge clk);
    send_token(32'h12, 1'b0);   // toggled at this negedge; push lands on E0+2
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;           // pop on the same edge as the push
    e = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || out_data !== e || fifo_cnt !== 3'd2) begin
      errors++;
      $display("FAIL pp_head: valid=%b data=%h cnt=%0d required 1 %h 2",
               out_valid, out_data, fifo_cnt, e);
    end
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (fifo_cnt !== 3'd2 || ack_o !== req_i) begin
      errors++;
      $display("FAIL pp_cnt: cnt=%0d ack=%b required 2 %b", fifo_cnt, ack_o, req_i);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        errors++;
        $display("FAIL pp_order_%0d: valid=%b data=%h required 1 %h", i, out_valid, out_data, e);
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_token(32'hC0 + DATA_W'(i), 1'b1);
    send_token(32'hC3, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;              // mid-cycle, token still in the synchroniser
    #1;
    checks++;
    if (fifo_cnt !== 3'd0 || ack_o !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: cnt=%0d ack=%b valid=%b required 0 0 0", fifo_cnt, ack_o, out_valid);
    end
    req_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (fifo_cnt !== 3'd0 || ack_o !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_spurious: cnt=%0d ack=%b valid=%b required 0 0 0",
               fifo_cnt, ack_o, out_valid);
    end
  endtask

`ifdef TAP_SYNC_RX_CNT_EN
  task automatic test_tok_cnt();
    logic [15:0] exp_cnt;
    logic [DATA_W-1:0] e;
    out_ready = 1'b1;
    @(negedge clk);
    force dut.tok_cnt_r = 16'hFFFE;
    @(negedge clk);
    release dut.tok_cnt_r;
    exp_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      send_token(32'hD0 + DATA_W'(i), 1'b1);
      exp_cnt = exp_cnt + 16'h0001;
      checks++;
      if (tok_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL tok_cnt_%0d: tok_cnt=%h required %h", i, tok_cnt, exp_cnt);
      end
      repeat (2) @(negedge clk);
      e = exp_q.pop_front();
    end
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef TAP_SYNC_RX_CNT_EN
    test_tok_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
